key_entry_sequencer: RTL

KEY_ENTRY_SEQUENCER -- requirements
Module: key_entry_sequencer

---
 rtl/key_entry_sequencer_pkg.sv | 13 +
 rtl/key_entry_sequencer_sync2.sv | 12 +
 rtl/key_entry_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/key_entry_sequencer_pkg.sv
// key_entry_sequencer_pkg: shared state encoding, counter width and default timings for the keypad sequencer.
package key_entry_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, PRE, SETUP, PRESS, GAP, WAIT_RES, DONE} state_t;
  localparam int CNT_W = 26;
  localparam int unsigned DEF_SETUP_CYC = 15_000_000;
  localparam int unsigned DEF_HOLD_CYC = 15_000_000;
  localparam int unsigned DEF_GAP_CYC = 5_000_000;
  localparam int unsigned DEF_TIMEOUT_CYC = 50_000_000;
  // A phase of p cycles loads p-1; zero is treated as a one-cycle phase.
  function automatic logic [CNT_W-1:0] load_val(input int unsigned p);
    return (p == 0) ? '0 : CNT_W'(p - 1);
  endfunction
endpackage

// File: rtl/key_entry_sequencer_sync2.sv
// sync2: two-flop synchronizer for an asynchronous single-bit indicator.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/key_entry_sequencer.sv
// key_entry_sequencer: presents a 4-digit code to a password lock via USERIN/KEY strobes and reports its verdict.
module key_entry_sequencer
  import key_entry_sequencer_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC = DEF_GAP_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] code,
  input  logic        LEDG,
  input  logic        LEDR,
  output logic [3:0]  USERIN,
  output logic [3:0]  KEY,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [15:0] code_q;
  logic [1:0] idx, nidx;
  logic lg_s, lr_s, verdict;
  sync2 u_sync_g (.clk(clk_50), .rst_n(rst), .d(LEDG), .q(lg_s));
  sync2 u_sync_r (.clk(clk_50), .rst_n(rst), .d(LEDR), .q(lr_s));
  assign nidx = idx - 2'd1;
  assign verdict = lr_s || lg_s || cnt == '0;
  always_ff @(posedge clk_50 or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      code_q <= '0;
      idx <= '0;
      USERIN <= '0;
      KEY <= 4'hf;
      {busy, done, pass, fail, timeout} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          code_q <= code;
          busy <= 1'b1;
          {pass, fail, timeout} <= '0;
          idx <= 2'd3;
          USERIN <= code[15:12];
          cnt <= load_val(SETUP_CYC);
          state <= PRE;
        end
        PRE: if (cnt == '0) begin
          USERIN <= code_q[15:12];
          cnt <= load_val(SETUP_CYC);
          state <= SETUP;
        end else cnt <= cnt - 1'b1;
        SETUP: if (cnt == '0) begin
          KEY <= ~(4'b0001 << idx);
          cnt <= load_val(HOLD_CYC);
          state <= PRESS;
        end else cnt <= cnt - 1'b1;
        PRESS: if (cnt == '0) begin
          KEY <= 4'hf;
          cnt <= load_val(GAP_CYC);
          state <= GAP;
        end else cnt <= cnt - 1'b1;
        GAP: if (cnt == '0) begin
          if (idx != 2'd0) begin
            idx <= nidx;
            USERIN <= code_q[{nidx, 2'b00} +: 4];
            cnt <= load_val(SETUP_CYC);
            state <= SETUP;
          end else begin
            cnt <= load_val(TIMEOUT_CYC);
            state <= WAIT_RES;
          end
        end else cnt <= cnt - 1'b1;
        WAIT_RES: if (verdict) begin
          // Reject wins over open when both indicators arrive together.
          fail <= lr_s;
          pass <= lg_s && !lr_s;
          timeout <= !lr_s && !lg_s;
          done <= 1'b1;
          busy <= 1'b0;
          cnt <= '0;
          state <= DONE;
        end else cnt <= cnt - 1'b1;
        default: begin
          cnt <= '0;
          state <= IDLE;
        end
      endcase
    end
endmodule
